// File: rtl/decode_issue_controller.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_controller
// Description : Issue register between decode and execute. A pending-write
//               scoreboard stalls RAW/WAW hazards, an in-flight write cap
//               limits outstanding writes, and serialising ops issue alone.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_controller #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              dec_valid_i,
    output logic                              dec_ready_o,
    input  logic                              dec_write_enable_i,
    input  logic [4:0]                        dec_rd_address_i,
    input  logic [4:0]                        dec_rs1_address_i,
    input  logic [4:0]                        dec_rs2_address_i,
    input  logic                              dec_serialize_i,
    output logic                              issue_valid_o,
    input  logic                              issue_ready_i,
    output logic                              issue_write_enable_o,
    output logic [4:0]                        issue_rd_address_o,
    output logic [4:0]                        issue_rs1_address_o,
    output logic [4:0]                        issue_rs2_address_o,
    input  logic                              wb_valid_i,
    input  logic [4:0]                        wb_rd_address_i,
    input  logic                              flush_i,
    output logic [31:0]                       pending_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
    output logic                              protocol_error_o
);

    localparam int                CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       pending;
    logic [31:0]       pending_next;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_next;
    logic              issue_valid;
    logic              issue_we;
    logic [4:0]        issue_rd;
    logic [4:0]        issue_rs1;
    logic [4:0]        issue_rs2;
    logic              perr;

    logic              dec_writes;
    logic              hazard;
    logic              full;
    logic              issue_free;
    logic              accept;
    logic              alloc;
    logic              wb_hit;
    logic              wb_err;
    logic              squash;
    logic              squash_dec;

    // pending[0] is held at zero, so x0 sources never create a hazard
    assign dec_writes = dec_write_enable_i & (dec_rd_address_i != 5'd0);
    assign hazard     = pending[dec_rs1_address_i] | pending[dec_rs2_address_i]
                      | (dec_write_enable_i & pending[dec_rd_address_i]);
    assign full       = (inflight == CNT_MAX) & dec_writes;
    assign issue_free = ~issue_valid | issue_ready_i;
    assign dec_ready_o = (state == ST_RUN) & ~flush_i & ~hazard & ~full & issue_free;
    assign accept     = dec_valid_i & dec_ready_o;
    assign alloc      = accept & dec_writes;

    assign wb_hit     = wb_valid_i & (wb_rd_address_i != 5'd0) & pending[wb_rd_address_i];
    assign wb_err     = wb_valid_i & (wb_rd_address_i != 5'd0) & ~pending[wb_rd_address_i];

    // A squashed write only gives back its slot if it still owns the pending
    // bit and a same-cycle writeback is not already retiring that register.
    assign squash     = flush_i & issue_valid & issue_we;
    assign squash_dec = squash & pending[issue_rd]
                      & ~(wb_hit & (wb_rd_address_i == issue_rd));

    always_comb begin
        pending_next = pending;
        if (wb_hit) begin
            pending_next[wb_rd_address_i] = 1'b0;
        end
        if (squash) begin
            pending_next[issue_rd] = 1'b0;
        end
        if (alloc) begin
            pending_next[dec_rd_address_i] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        inflight_next = inflight;
        if (alloc) begin
            inflight_next = inflight_next + CNT_ONE;
        end
        if (wb_hit) begin
            inflight_next = inflight_next - CNT_ONE;
        end
        if (squash_dec) begin
            inflight_next = inflight_next - CNT_ONE;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (accept & dec_serialize_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Flush empties the issue register, so only the counter matters
                if (flush_i) begin
                    if (inflight_next == '0) begin
                        state_next = ST_RUN;
                    end
                end else if ((inflight == '0) & issue_free) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_RUN;
            pending  <= '0;
            inflight <= '0;
            perr     <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            inflight <= inflight_next;
            if (wb_err) begin
                perr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_valid <= 1'b0;
            issue_we    <= 1'b0;
            issue_rd    <= 5'd0;
            issue_rs1   <= 5'd0;
            issue_rs2   <= 5'd0;
        end else if (accept) begin
            issue_valid <= 1'b1;
            issue_we    <= dec_writes;
            issue_rd    <= dec_rd_address_i;
            issue_rs1   <= dec_rs1_address_i;
            issue_rs2   <= dec_rs2_address_i;
        end else if (flush_i | (issue_valid & issue_ready_i)) begin
            issue_valid <= 1'b0;
        end
    end

    assign issue_valid_o        = issue_valid;
    assign issue_write_enable_o = issue_we;
    assign issue_rd_address_o   = issue_rd;
    assign issue_rs1_address_o  = issue_rs1;
    assign issue_rs2_address_o  = issue_rs2;
    assign pending_o            = pending;
    assign inflight_o           = inflight;
    assign protocol_error_o     = perr;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_controller
// Description : Directed bench with an issue-order scoreboard for
//               decode_issue_controller (MAX_INFLIGHT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic        dec_write_enable_i;
    logic [4:0]  dec_rd_address_i;
    logic [4:0]  dec_rs1_address_i;
    logic [4:0]  dec_rs2_address_i;
    logic        dec_serialize_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic        issue_write_enable_o;
    logic [4:0]  issue_rd_address_o;
    logic [4:0]  issue_rs1_address_o;
    logic [4:0]  issue_rs2_address_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_address_i;
    logic        flush_i;
    logic [31:0] pending_o;
    logic [2:0]  inflight_o;
    logic        protocol_error_o;

    int compared   = 0;
    int mismatched = 0;
    int stall;

    // {write_enable, rd, rs1, rs2} in issue order
    logic [15:0] sb[$];

    decode_issue_controller #(.MAX_INFLIGHT(4)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .dec_valid_i          (dec_valid_i),
        .dec_ready_o          (dec_ready_o),
        .dec_write_enable_i   (dec_write_enable_i),
        .dec_rd_address_i     (dec_rd_address_i),
        .dec_rs1_address_i    (dec_rs1_address_i),
        .dec_rs2_address_i    (dec_rs2_address_i),
        .dec_serialize_i      (dec_serialize_i),
        .issue_valid_o        (issue_valid_o),
        .issue_ready_i        (issue_ready_i),
        .issue_write_enable_o (issue_write_enable_o),
        .issue_rd_address_o   (issue_rd_address_o),
        .issue_rs1_address_o  (issue_rs1_address_o),
        .issue_rs2_address_o  (issue_rs2_address_o),
        .wb_valid_i           (wb_valid_i),
        .wb_rd_address_i      (wb_rd_address_i),
        .flush_i              (flush_i),
        .pending_o            (pending_o),
        .inflight_o           (inflight_o),
        .protocol_error_o     (protocol_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic we, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic ser);
        dec_valid_i        = 1'b1;
        dec_write_enable_i = we;
        dec_rd_address_i   = rd;
        dec_rs1_address_i  = rs1;
        dec_rs2_address_i  = rs2;
        dec_serialize_i    = ser;
    endtask

    task automatic idle();
        dec_valid_i        = 1'b0;
        dec_write_enable_i = 1'b0;
        dec_rd_address_i   = 5'd0;
        dec_rs1_address_i  = 5'd0;
        dec_rs2_address_i  = 5'd0;
        dec_serialize_i    = 1'b0;
    endtask

    // Inputs change just after posedge, so the negedge sees what the next
    // posedge will act on: pop what leaves the issue register, push what enters.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (issue_valid_o && (issue_ready_i || flush_i)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    chk("issue_fields",
                        32'({issue_write_enable_o, issue_rd_address_o,
                             issue_rs1_address_o, issue_rs2_address_o}),
                        32'(sb.pop_front()));
                end
            end
            if (dec_valid_i && dec_ready_o) begin
                sb.push_back({dec_write_enable_i & (dec_rd_address_i != 5'd0),
                              dec_rd_address_i, dec_rs1_address_i, dec_rs2_address_i});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni        = 1'b0;
        idle();
        issue_ready_i = 1'b0;
        wb_valid_i    = 1'b0;
        wb_rd_address_i = 5'd0;
        flush_i       = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("rst_issue_fields", 32'({issue_write_enable_o, issue_rd_address_o,
                                     issue_rs1_address_o, issue_rs2_address_o}), 32'd0);
        chk("rst_pending", pending_o, 32'd0);
        chk("rst_inflight", 32'(inflight_o), 32'd0);
        chk("rst_perr", 32'(protocol_error_o), 32'd0);
        chk("rst_ready", 32'(dec_ready_o), 32'd1);

        // Back-to-back independent writes
        issue_ready_i = 1'b1;
        present(1'b1, 5'd1, 5'd5, 5'd6, 1'b0);
        #1 chk("b2b_ready0", 32'(dec_ready_o), 32'd1);
        cyc();
        present(1'b1, 5'd2, 5'd5, 5'd6, 1'b0);
        #1;
        chk("b2b_ready1", 32'(dec_ready_o), 32'd1);
        chk("b2b_valid1", 32'(issue_valid_o), 32'd1);
        chk("b2b_inflight1", 32'(inflight_o), 32'd1);
        chk("b2b_pending1", pending_o, 32'h2);
        cyc();
        idle();
        #1;
        chk("b2b_inflight2", 32'(inflight_o), 32'd2);
        chk("b2b_pending2", pending_o, 32'h6);
        chk("b2b_valid2", 32'(issue_valid_o), 32'd1);
        cyc();
        chk("b2b_drained", 32'(issue_valid_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd1;
        cyc();
        wb_rd_address_i = 5'd2;
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("b2b_wb_pending", pending_o, 32'h0);
        chk("b2b_wb_inflight", 32'(inflight_o), 32'd0);

        // RAW stall: writeback in the third stalled window
        present(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        #1 chk("raw_first_ready", 32'(dec_ready_o), 32'd1);
        cyc();
        present(1'b1, 5'd10, 5'd3, 5'd0, 1'b0);
        stall = 0;
        #1;
        while (!dec_ready_o && stall < 10) begin
            stall++;
            wb_valid_i = (stall == 3);
            wb_rd_address_i = 5'd3;
            cyc();
            wb_valid_i = 1'b0;
            #1;
        end
        chk("raw_stall_count", 32'(stall), 32'd3);
        cyc();
        idle();
        #1;
        chk("raw_pending", pending_o, 32'h400);
        chk("raw_inflight", 32'(inflight_o), 32'd1);
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd10;
        cyc();
        wb_valid_i = 1'b0;
        #1 chk("raw_clean", 32'(inflight_o), 32'd0);

        // In-flight cap
        for (int r = 1; r <= 4; r++) begin
            present(1'b1, 5'(r), 5'd0, 5'd0, 1'b0);
            cyc();
        end
        present(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        #1;
        chk("full_inflight", 32'(inflight_o), 32'd4);
        chk("full_stall0", 32'(dec_ready_o), 32'd0);
        cyc();
        chk("full_stall1", 32'(dec_ready_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd2;
        #1 chk("full_stall_wb", 32'(dec_ready_o), 32'd0);
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("full_after_wb_inflight", 32'(inflight_o), 32'd3);
        chk("full_after_wb_ready", 32'(dec_ready_o), 32'd1);
        cyc();
        idle();
        #1;
        chk("full_refill_inflight", 32'(inflight_o), 32'd4);
        chk("full_refill_pending", pending_o, 32'h3A);
        foreach (sb[i]) begin end
        wb_valid_i = 1'b1;
        wb_rd_address_i = 5'd1; cyc();
        wb_rd_address_i = 5'd3; cyc();
        wb_rd_address_i = 5'd4; cyc();
        wb_rd_address_i = 5'd5; cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("full_clean_inflight", 32'(inflight_o), 32'd0);
        chk("full_clean_pending", pending_o, 32'h0);

        // Flush of a held write
        issue_ready_i = 1'b0;
        present(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        #1 chk("flush_accept_ready", 32'(dec_ready_o), 32'd1);
        cyc();
        present(1'b1, 5'd8, 5'd0, 5'd0, 1'b0);
        flush_i = 1'b1;
        #1;
        chk("flush_blocks_accept", 32'(dec_ready_o), 32'd0);
        chk("flush_pre_pending", pending_o, 32'h80);
        chk("flush_pre_inflight", 32'(inflight_o), 32'd1);
        cyc();
        flush_i = 1'b0;
        idle();
        #1;
        chk("flush_valid", 32'(issue_valid_o), 32'd0);
        chk("flush_pending", pending_o, 32'h0);
        chk("flush_inflight", 32'(inflight_o), 32'd0);

        // Flush together with writeback of an older write
        issue_ready_i = 1'b1;
        present(1'b1, 5'd12, 5'd0, 5'd0, 1'b0);
        cyc();
        present(1'b1, 5'd13, 5'd0, 5'd0, 1'b0);
        cyc();
        idle();
        issue_ready_i = 1'b0;
        #1 chk("flushwb_pre_inflight", 32'(inflight_o), 32'd2);
        flush_i = 1'b1; wb_valid_i = 1'b1; wb_rd_address_i = 5'd12;
        cyc();
        flush_i = 1'b0; wb_valid_i = 1'b0;
        #1;
        chk("flushwb_inflight", 32'(inflight_o), 32'd0);
        chk("flushwb_pending", pending_o, 32'h0);
        chk("flushwb_valid", 32'(issue_valid_o), 32'd0);

        // Serialising instruction with two writes outstanding
        issue_ready_i = 1'b1;
        present(1'b1, 5'd1, 5'd0, 5'd0, 1'b0);
        cyc();
        present(1'b1, 5'd2, 5'd0, 5'd0, 1'b0);
        cyc();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        #1 chk("ser_fence_ready", 32'(dec_ready_o), 32'd1);
        cyc();
        issue_ready_i = 1'b0;
        present(1'b1, 5'd20, 5'd0, 5'd0, 1'b0);
        #1 chk("ser_drain_block", 32'(dec_ready_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd1;
        cyc();
        wb_rd_address_i = 5'd2;
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("ser_inflight_zero", 32'(inflight_o), 32'd0);
        chk("ser_fence_held", 32'(dec_ready_o), 32'd0);
        issue_ready_i = 1'b1;
        #1 chk("ser_still_drain", 32'(dec_ready_o), 32'd0);
        cyc();
        chk("ser_run_ready", 32'(dec_ready_o), 32'd1);
        chk("ser_fence_gone", 32'(issue_valid_o), 32'd0);
        cyc();
        idle();
        #1 chk("ser_after_pending", pending_o, 32'h100000);
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd20;
        cyc();
        wb_valid_i = 1'b0;

        // Writeback protocol errors
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd0;
        cyc();
        wb_valid_i = 1'b0;
        #1 chk("perr_x0_ignored", 32'(protocol_error_o), 32'd0);
        wb_valid_i = 1'b1; wb_rd_address_i = 5'd9;
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("perr_set", 32'(protocol_error_o), 32'd1);
        chk("perr_inflight", 32'(inflight_o), 32'd0);
        cyc();
        cyc();
        chk("perr_sticky", 32'(protocol_error_o), 32'd1);

        // Asynchronous reset in the middle of a stall
        issue_ready_i = 1'b0;
        present(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        cyc();
        present(1'b1, 5'd11, 5'd3, 5'd0, 1'b0);
        #1;
        chk("rstmid_stalled", 32'(dec_ready_o), 32'd0);
        chk("rstmid_pre_pending", pending_o, 32'h8);
        idle();
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk("rstmid_valid", 32'(issue_valid_o), 32'd0);
        chk("rstmid_fields", 32'({issue_write_enable_o, issue_rd_address_o,
                                  issue_rs1_address_o, issue_rs2_address_o}), 32'd0);
        chk("rstmid_pending", pending_o, 32'h0);
        chk("rstmid_inflight", 32'(inflight_o), 32'd0);
        chk("rstmid_perr", 32'(protocol_error_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
